aes_reg_bank: RTL and testbench
===============================

AES_REG_BANK -- requirements
Module: aes_reg_bank

Interface
REQ-001 SHALL expose parameters (name, default, meaning), one per line:
- SHARES, 1, masking shares per byte (1..4); BW = 8*SHARES
- KEY_BYTES, 32, key register bytes (16/24/32)
- NOISE_SZ, 7, noise bytes
- OBUF_DEPTH, 2, result buffer entries (>=1)
- DESTRUCT_CYCLES, 3, key-destruct overwrite cycles (>=1)
- KEYEXPPROD_REG_EN, 1, register round constant, else tie to 0

REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk_i, in, 1, clock, rising edge
- srst_i, in, 1, synchronous active-high reset
- start_i, in, 1, load new block/key/noise
- ctrl_st_ke, in, 1, update round key
- ctrl_st_code, in, 1, update state, rotate noise
- ctrl_st_unmask, in, 1, push unmasked result
- mode_i, in, 2, 01=128, 10=192, 11=256, 00 illegal
- state_input_i, in, 16*BW, initial state
- state_code_i, in, 16*BW, round output state
- key_input_i, in, KEY_BYTES*BW, initial key
- key_ke_i, in, KEY_BYTES*BW, expanded key
- noise_input_i, in, NOISE_SZ*BW, masking noise
- keyexpprod_i, in, 8, round constant
- rand_i, in, KEY_BYTES*BW, fresh randomness
- key_destruct_i, in, 1, start key destruction
- res_ready_i, in, 1, consumer ready
- state_o, out, 16*BW, current state
- key_o, out, KEY_BYTES*BW, current round key
- noise_o, out, NOISE_SZ*BW, current noise
- keyexpprod_o, out, 8, registered round constant
- res_data_o, out, 128, head result (standard basis)
- res_valid_o, out, 1, buffer non-empty
- res_overflow_o, out, 1, sticky result-drop flag
- busy_o, out, 1, destruction in progress
- start_rej_o, out, 1, one-cycle pulse: start_i ignored
- mode_err_o, out, 1, one-cycle pulse: start_i with mode_i=00

Function
REQ-003 SHALL implement FSM IDLE/DESTRUCT; key_destruct_i in IDLE -> DESTRUCT with counter=DESTRUCT_CYCLES-1; counter decrements each cycle; DESTRUCT at 0 -> IDLE.
REQ-004 SHALL, in every DESTRUCT cycle including entry cycle, load key_o<=rand_i, state_o<=rand_i low 16*BW bits, noise_o<=rand_i low NOISE_SZ*BW bits; busy_o=1 iff DESTRUCT.
REQ-005 SHALL give key_o priority: srst_i > destruct (entry or DESTRUCT) > start_i > ctrl_st_ke.
REQ-006 SHALL, on start_i in IDLE without key_destruct_i, load key_input_i with bytes at index >=16 (mode 01 or 00) or >=24 (mode 10) forced to zero; mode 00 treated as 128 and pulses mode_err_o next cycle.
REQ-007 SHALL ignore start_i, ctrl_st_ke, ctrl_st_code while in DESTRUCT, and pulse start_rej_o the cycle after any ignored start_i.
REQ-008 SHALL load state_o from state_input_i on start_i, else from state_code_i on ctrl_st_code; start_i wins.
REQ-009 SHALL load noise_o on start_i; on ctrl_st_code rotate left by one BW-byte (top byte to byte 0).
REQ-010 SHALL set keyexpprod_o to 0 on start_i, else keyexpprod_i, one-cycle latency; constant 0 when KEYEXPPROD_REG_EN=0.
REQ-011 SHALL, on ctrl_st_unmask, XOR-fold the SHARES shares of state_o, convert to standard basis, push into FIFO (same-cycle combinational, written at clock edge).
REQ-012 SHALL pop when res_valid_o && res_ready_i; first-word-fallthrough; res_data_o = 0 when empty.
REQ-013 SHALL, on push when full and no simultaneous pop, drop the result and set res_overflow_o (sticky until srst_i); push+pop when full succeeds.
REQ-014 SHALL flush the FIFO on key_destruct_i (entry cycle) without setting overflow.

Reset
REQ-015 SHALL, on srst_i, zero state_o, key_o, noise_o, keyexpprod_o, FIFO contents/pointers, res_overflow_o, pulses, enter IDLE; srst_i mid-destruct aborts to IDLE.

Structure
REQ-016 SHALL place mode encodings, FSM state type, BW derivation in shared package aes_reg_pkg.
REQ-017 SHALL instantiate one sub-module aes_share_unmask (share XOR-fold plus basis-to-standard map, combinational).

Verification
REQ-018 SHARES=2, start_i with both shares of every byte =8'hA5, one ctrl_st_unmask -> res_valid_o=1 next cycle, res_data_o=128'h0.
REQ-019 mode_i=01, start_i, key_input_i all bytes 8'hFF -> key_o bytes 0..15 =FF, bytes 16..31 =00; mode_i=00 -> same plus mode_err_o pulse.
REQ-020 key_destruct_i, DESTRUCT_CYCLES=3, rand_i stepping 1,2,3 -> busy_o high 3 cycles, key_o=3 after, start_i during busy -> start_rej_o pulse, state unchanged.
REQ-021 OBUF_DEPTH=2, res_ready_i=0, 3 unmask pushes -> res_valid_o=1, res_overflow_o=1, first two results popped in order.
REQ-022 noise_input_i bytes 0..6 = 00..06, two ctrl_st_code -> noise_o bytes 0..6 = 05,06,00,01,02,03,04; srst_i -> all outputs 0.

Source files
------------

// File: rtl/aes_reg_pkg.sv
// Shared definitions for the AES register bank: key-length modes, destruct FSM states,
// share-width derivation and the masked-to-standard basis map.
package aes_reg_pkg;

    typedef enum logic [1:0] {
        MODE_ILL = 2'b00,
        MODE_128 = 2'b01,
        MODE_192 = 2'b10,
        MODE_256 = 2'b11
    } aes_mode_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_DESTRUCT = 1'b1
    } destruct_state_e;

    function automatic int share_bw(input int shares);
        return 8 * shares;
    endfunction

    // Row r lists the masked-basis bits whose parity gives standard-basis bit r.
    localparam logic [7:0][7:0] BASIS_ROWS = {
        8'h80, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03
    };

endpackage

// File: rtl/aes_share_unmask.sv
// Combinational unmasking: XOR-folds the shares of each state byte and maps the
// folded byte from the masked basis into the standard AES basis.
module aes_share_unmask
    import aes_reg_pkg::*;
#(
    parameter int SHARES = 1
) (
    input  logic [16*share_bw(SHARES)-1:0] state,
    output logic [127:0]                   data
);

    localparam int BW = share_bw(SHARES);

    logic [7:0] folded [16];

    always_comb begin
        data = '0;
        for (int b = 0; b < 16; b++) begin
            folded[b] = '0;
            for (int s = 0; s < SHARES; s++) begin
                folded[b] = folded[b] ^ state[b*BW + s*8 +: 8];
            end
            for (int r = 0; r < 8; r++) begin
                data[b*8 + r] = ^(folded[b] & BASIS_ROWS[r]);
            end
        end
    end

endmodule

// File: rtl/aes_reg_bank.sv
// Masked AES state/key/noise register bank with key destruction sequencer and an
// unmasked-result FIFO.
module aes_reg_bank
    import aes_reg_pkg::*;
#(
    parameter int SHARES            = 1,
    parameter int KEY_BYTES         = 32,
    parameter int NOISE_SZ          = 7,
    parameter int OBUF_DEPTH        = 2,
    parameter int DESTRUCT_CYCLES   = 3,
    parameter bit KEYEXPPROD_REG_EN = 1,
    localparam int BW               = share_bw(SHARES)
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic                    start_i,
    input  logic                    ctrl_st_ke,
    input  logic                    ctrl_st_code,
    input  logic                    ctrl_st_unmask,
    input  logic [1:0]              mode_i,
    input  logic [16*BW-1:0]        state_input_i,
    input  logic [16*BW-1:0]        state_code_i,
    input  logic [KEY_BYTES*BW-1:0] key_input_i,
    input  logic [KEY_BYTES*BW-1:0] key_ke_i,
    input  logic [NOISE_SZ*BW-1:0]  noise_input_i,
    input  logic [7:0]              keyexpprod_i,
    input  logic [KEY_BYTES*BW-1:0] rand_i,
    input  logic                    key_destruct_i,
    input  logic                    res_ready_i,
    output logic [16*BW-1:0]        state_o,
    output logic [KEY_BYTES*BW-1:0] key_o,
    output logic [NOISE_SZ*BW-1:0]  noise_o,
    output logic [7:0]              keyexpprod_o,
    output logic [127:0]            res_data_o,
    output logic                    res_valid_o,
    output logic                    res_overflow_o,
    output logic                    busy_o,
    output logic                    start_rej_o,
    output logic                    mode_err_o
);

    localparam int SW  = 16 * BW;
    localparam int KW  = KEY_BYTES * BW;
    localparam int NW  = NOISE_SZ * BW;
    localparam int CW  = (DESTRUCT_CYCLES > 1) ? $clog2(DESTRUCT_CYCLES) : 1;
    localparam int PW  = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int NCW = $clog2(OBUF_DEPTH + 1);

    destruct_state_e fsm_q, fsm_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            idle, destruct_entry, destruct_now, start_acc, start_ign;
    logic [SW-1:0]   st_q;
    logic [KW-1:0]   key_q, key_start;
    logic [NW-1:0]   noise_q, noise_rot;
    logic            start_rej_q, mode_err_q;

    assign idle           = (fsm_q == ST_IDLE);
    assign destruct_entry = idle & key_destruct_i;
    assign destruct_now   = destruct_entry | ~idle;
    assign start_acc      = start_i & ~destruct_now;
    assign start_ign      = start_i & destruct_now;

    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        case (fsm_q)
            ST_IDLE: begin
                if (key_destruct_i) begin
                    fsm_d = ST_DESTRUCT;
                    cnt_d = CW'(DESTRUCT_CYCLES - 1);
                end
            end
            ST_DESTRUCT: begin
                if (cnt_q == '0) fsm_d = ST_IDLE;
                else             cnt_d = cnt_q - 1'b1;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Key bytes beyond the selected key length are cleared; the illegal mode behaves as 128.
    always_comb begin
        key_start = key_input_i;
        for (int i = 0; i < KEY_BYTES; i++) begin
            if ((i >= 16 && (mode_i == MODE_128 || mode_i == MODE_ILL)) ||
                (i >= 24 && mode_i == MODE_192)) begin
                key_start[i*BW +: BW] = '0;
            end
        end
    end

    if (NOISE_SZ > 1) begin : g_rot
        assign noise_rot = {noise_q[NW-BW-1:0], noise_q[NW-1 -: BW]};
    end else begin : g_no_rot
        assign noise_rot = noise_q;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            fsm_q       <= ST_IDLE;
            cnt_q       <= '0;
            st_q        <= '0;
            key_q       <= '0;
            noise_q     <= '0;
            start_rej_q <= 1'b0;
            mode_err_q  <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            start_rej_q <= start_ign;
            mode_err_q  <= start_acc & (mode_i == MODE_ILL);
            if (destruct_now) begin
                key_q   <= rand_i;
                st_q    <= rand_i[SW-1:0];
                noise_q <= rand_i[NW-1:0];
            end else begin
                if (start_acc)       key_q <= key_start;
                else if (ctrl_st_ke) key_q <= key_ke_i;
                if (start_acc)         st_q <= state_input_i;
                else if (ctrl_st_code) st_q <= state_code_i;
                if (start_acc)         noise_q <= noise_input_i;
                else if (ctrl_st_code) noise_q <= noise_rot;
            end
        end
    end

    if (KEYEXPPROD_REG_EN) begin : g_kep
        logic [7:0] kep_q;
        always_ff @(posedge clk_i) begin
            if (srst_i) kep_q <= '0;
            else        kep_q <= start_acc ? 8'h00 : keyexpprod_i;
        end
        assign keyexpprod_o = kep_q;
    end else begin : g_no_kep
        assign keyexpprod_o = 8'h00;
    end

    // Result port: a word transfers on a clock edge where res_valid_o and res_ready_i are
    // both high; res_data_o shows the oldest word whenever res_valid_o is high.
    logic [127:0]   unmask_data;
    logic [127:0]   obuf_q [OBUF_DEPTH];
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [NCW-1:0] count_q;
    logic           full, push, pop, do_push, ovf_q;

    aes_share_unmask #(.SHARES(SHARES)) u_unmask (
        .state (st_q),
        .data  (unmask_data)
    );

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push    = ctrl_st_unmask;
    assign pop     = res_valid_o & res_ready_i;
    assign full    = (count_q == NCW'(OBUF_DEPTH));
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < OBUF_DEPTH; i++) obuf_q[i] <= '0;
        end else if (destruct_entry) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                obuf_q[wptr_q] <= unmask_data;
                wptr_q         <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            count_q <= count_q + NCW'(do_push) - NCW'(pop);
            if (push & full & ~pop) ovf_q <= 1'b1;
        end
    end

    assign state_o        = st_q;
    assign key_o          = key_q;
    assign noise_o        = noise_q;
    assign res_valid_o    = (count_q != '0);
    assign res_data_o     = res_valid_o ? obuf_q[rptr_q] : '0;
    assign res_overflow_o = ovf_q;
    assign busy_o         = ~idle;
    assign start_rej_o    = start_rej_q;
    assign mode_err_o     = mode_err_q;

endmodule

// File: tb/tb_aes_reg_bank.sv
// Randomized bench for aes_reg_bank: byte-level reference model, result scoreboard queue
// drained by an independent monitor, plus directed scenarios.
module tb_aes_reg_bank;

    localparam int SHARES = 2;
    localparam int KEY_BYTES = 32;
    localparam int NOISE_SZ = 7;
    localparam int DEPTH = 2;
    localparam int DCYC = 3;
    localparam int BW = 8 * SHARES;
    localparam int SW = 16 * BW;
    localparam int KW = KEY_BYTES * BW;
    localparam int NW = NOISE_SZ * BW;

    // clock / reset
    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic          srst_i = 1'b0, start_i = 1'b0, ctrl_st_ke = 1'b0, ctrl_st_code = 1'b0;
    logic          ctrl_st_unmask = 1'b0, key_destruct_i = 1'b0, res_ready_i = 1'b0;
    logic [1:0]    mode_i = 2'b01;
    logic [SW-1:0] state_input_i = '0, state_code_i = '0;
    logic [KW-1:0] key_input_i = '0, key_ke_i = '0, rand_i = '0;
    logic [NW-1:0] noise_input_i = '0;
    logic [7:0]    keyexpprod_i = '0;
    logic [SW-1:0] state_o;
    logic [KW-1:0] key_o;
    logic [NW-1:0] noise_o;
    logic [7:0]    keyexpprod_o;
    logic [127:0]  res_data_o;
    logic          res_valid_o, res_overflow_o, busy_o, start_rej_o, mode_err_o;

    aes_reg_bank #(
        .SHARES(SHARES), .KEY_BYTES(KEY_BYTES), .NOISE_SZ(NOISE_SZ),
        .OBUF_DEPTH(DEPTH), .DESTRUCT_CYCLES(DCYC), .KEYEXPPROD_REG_EN(1'b1)
    ) dut (
        .clk_i(clk), .srst_i(srst_i), .start_i(start_i), .ctrl_st_ke(ctrl_st_ke),
        .ctrl_st_code(ctrl_st_code), .ctrl_st_unmask(ctrl_st_unmask), .mode_i(mode_i),
        .state_input_i(state_input_i), .state_code_i(state_code_i),
        .key_input_i(key_input_i), .key_ke_i(key_ke_i), .noise_input_i(noise_input_i),
        .keyexpprod_i(keyexpprod_i), .rand_i(rand_i), .key_destruct_i(key_destruct_i),
        .res_ready_i(res_ready_i), .state_o(state_o), .key_o(key_o), .noise_o(noise_o),
        .keyexpprod_o(keyexpprod_o), .res_data_o(res_data_o), .res_valid_o(res_valid_o),
        .res_overflow_o(res_overflow_o), .busy_o(busy_o), .start_rej_o(start_rej_o),
        .mode_err_o(mode_err_o)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // reference model
    logic [SW-1:0] m_st = '0;
    logic [KW-1:0] m_key = '0;
    logic [NW-1:0] m_noise = '0;
    logic [7:0]    m_kep = '0;
    int            m_left = 0;
    int            m_count = 0;
    bit            m_ovf = 0, m_rej = 0, m_merr = 0;
    logic [127:0]  exp_q[$];

    function automatic logic [KW-1:0] rnd_vec();
        logic [KW-1:0] v;
        for (int i = 0; i < KW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [KW-1:0] masked_key(input logic [KW-1:0] k, input logic [1:0] m);
        int keep;
        keep = (m == 2'b11) ? 32 : (m == 2'b10) ? 24 : 16;
        for (int i = 0; i < KEY_BYTES; i++) if (i >= keep) k[i*BW +: BW] = '0;
        return k;
    endfunction

    function automatic logic [NW-1:0] rotate_noise(input logic [NW-1:0] n);
        logic [NW-1:0] r;
        for (int i = 0; i < NOISE_SZ; i++) r[i*BW +: BW] = n[((i + NOISE_SZ - 1) % NOISE_SZ)*BW +: BW];
        return r;
    endfunction

    // Standard-basis image of each masked-basis bit.
    function automatic logic [7:0] to_std(input logic [7:0] x);
        logic [7:0] col [8];
        logic [7:0] y;
        col[0] = 8'h01;
        for (int c = 1; c < 8; c++) col[c] = 8'((1 << c) | (1 << (c - 1)));
        y = '0;
        for (int c = 0; c < 8; c++) if (x[c]) y = y ^ col[c];
        return y;
    endfunction

    function automatic logic [127:0] unmask_ref(input logic [SW-1:0] st);
        logic [127:0] r;
        logic [7:0]   f;
        for (int b = 0; b < 16; b++) begin
            f = '0;
            for (int s = 0; s < SHARES; s++) f = f ^ st[(b*SHARES + s)*8 +: 8];
            r[b*8 +: 8] = to_std(f);
        end
        return r;
    endfunction

    // One clock: predict from current inputs, clock, then compare all outputs.
    task automatic step();
        logic [SW-1:0] n_st;
        logic [KW-1:0] n_key;
        logic [NW-1:0] n_noise;
        logic [127:0]  res;
        bit entry, dnow, sacc, pop, accept, flush;
        n_st = m_st; n_key = m_key; n_noise = m_noise;
        accept = 0; flush = 0;
        res = unmask_ref(m_st);
        if (srst_i) begin
            n_st = '0; n_key = '0; n_noise = '0; m_kep = '0;
            m_left = 0; m_count = 0; m_ovf = 0; m_rej = 0; m_merr = 0; flush = 1;
        end else begin
            entry = (m_left == 0) && key_destruct_i;
            dnow = entry || (m_left != 0);
            sacc = start_i && !dnow;
            m_rej = start_i && !sacc;
            m_merr = sacc && (mode_i == 2'b00);
            m_kep = sacc ? 8'h00 : keyexpprod_i;
            if (dnow) begin
                n_key = rand_i; n_st = rand_i[SW-1:0]; n_noise = rand_i[NW-1:0];
            end else begin
                if (sacc) n_key = masked_key(key_input_i, mode_i);
                else if (ctrl_st_ke) n_key = key_ke_i;
                if (sacc) n_st = state_input_i;
                else if (ctrl_st_code) n_st = state_code_i;
                if (sacc) n_noise = noise_input_i;
                else if (ctrl_st_code) n_noise = rotate_noise(m_noise);
            end
            if (entry) m_left = DCYC;
            else if (m_left != 0) m_left = m_left - 1;
            if (entry) begin
                flush = 1; m_count = 0;
            end else begin
                pop = (m_count > 0) && res_ready_i;
                if (ctrl_st_unmask) begin
                    if (m_count - int'(pop) < DEPTH) accept = 1;
                    else m_ovf = 1;
                end
                m_count = m_count - int'(pop) + int'(accept);
            end
        end
        @(posedge clk);
        #1;
        m_st = n_st; m_key = n_key; m_noise = n_noise;
        if (flush) exp_q.delete();
        if (accept) exp_q.push_back(res);
        check("state_o", state_o, m_st);
        check("key_o", key_o, m_key);
        check("noise_o", noise_o, m_noise);
        check("keyexpprod_o", keyexpprod_o, m_kep);
        check("busy_o", busy_o, m_left != 0);
        check("res_valid_o", res_valid_o, m_count != 0);
        check("res_overflow_o", res_overflow_o, m_ovf);
        check("start_rej_o", start_rej_o, m_rej);
        check("mode_err_o", mode_err_o, m_merr);
        if (m_count == 0) check("res_data_empty", res_data_o, '0);
    endtask

    task automatic idle_ctrl();
        srst_i = 0; start_i = 0; ctrl_st_ke = 0; ctrl_st_code = 0;
        ctrl_st_unmask = 0; key_destruct_i = 0;
    endtask

    // scoreboard monitor: compares every word the consumer takes
    always @(negedge clk) begin
        if (!srst_i && res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) check("res_unexpected", res_data_o, 'x);
            else check("res_data_o", res_data_o, exp_q.pop_front());
        end
    end

    initial begin
        logic [NW-1:0] nexp;
        int nv[7];
        nv = '{5, 6, 0, 1, 2, 3, 4};

        // reset with noisy inputs
        srst_i = 1; start_i = 1; ctrl_st_code = 1; key_destruct_i = 1; rand_i = rnd_vec();
        step(); step();
        idle_ctrl();
        keyexpprod_i = 8'h1B;
        step();

        // all-equal shares fold to zero
        start_i = 1; mode_i = 2'b11;
        for (int i = 0; i < 16 * SHARES; i++) state_input_i[i*8 +: 8] = 8'hA5;
        step();
        start_i = 0; ctrl_st_unmask = 1; res_ready_i = 0;
        step();
        ctrl_st_unmask = 0;
        check("fold_zero_valid", res_valid_o, 1'b1);
        check("fold_zero_data", res_data_o, '0);
        res_ready_i = 1;
        step();

        // 128-bit key masking, then illegal mode
        for (int i = 0; i < KEY_BYTES * SHARES; i++) key_input_i[i*8 +: 8] = 8'hFF;
        start_i = 1; mode_i = 2'b01;
        step();
        check("key_128", key_o, {256'h0, {32{8'hFF}}});
        mode_i = 2'b00; key_input_i = ~key_input_i;
        step();
        key_input_i = ~key_input_i;
        step();
        start_i = 0;
        check("key_illegal", key_o, {256'h0, {32{8'hFF}}});
        mode_i = 2'b10;
        start_i = 1; step(); start_i = 0;
        check("key_192", key_o, {128'h0, {48{8'hFF}}});

        // noise rotation
        for (int i = 0; i < NOISE_SZ; i++) noise_input_i[i*BW +: BW] = {8'(i), 8'(i)};
        start_i = 1; step(); start_i = 0;
        ctrl_st_code = 1; state_code_i = rnd_vec();
        step(); state_code_i = rnd_vec(); step();
        ctrl_st_code = 0;
        for (int i = 0; i < NOISE_SZ; i++) nexp[i*BW +: BW] = {8'(nv[i]), 8'(nv[i])};
        check("noise_rot2", noise_o, nexp);

        // overflow on third push into a full 2-entry buffer
        res_ready_i = 0; ctrl_st_unmask = 1;
        step();
        ctrl_st_code = 1; state_code_i = rnd_vec();
        step();
        state_code_i = rnd_vec();
        step();
        ctrl_st_code = 0; ctrl_st_unmask = 0;
        check("ovf_valid", res_valid_o, 1'b1);
        check("ovf_flag", res_overflow_o, 1'b1);
        res_ready_i = 1;
        step(); step(); step();

        // key destruction with stepped randomness and a start during busy
        key_destruct_i = 1; rand_i = rnd_vec();
        step();
        key_destruct_i = 0; rand_i = 1; start_i = 1;
        step();
        start_i = 0; rand_i = 2;
        check("destruct_busy", busy_o, 1'b1);
        step();
        rand_i = 3;
        step();
        check("destruct_key", key_o, 512'd3);
        check("destruct_state", state_o, 512'd3);
        check("destruct_done", busy_o, 1'b0);
        step();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            srst_i = ($urandom_range(0, 99) == 0);
            key_destruct_i = ($urandom_range(0, 39) == 0);
            start_i = !key_destruct_i && ($urandom_range(0, 7) == 0);
            mode_i = 2'($urandom_range(0, 3));
            ctrl_st_ke = 1'($urandom_range(0, 1));
            ctrl_st_code = ($urandom_range(0, 2) == 0);
            ctrl_st_unmask = !key_destruct_i && ($urandom_range(0, 2) == 0);
            res_ready_i = 1'($urandom_range(0, 1));
            state_input_i = rnd_vec(); state_code_i = rnd_vec();
            key_input_i = rnd_vec(); key_ke_i = rnd_vec(); rand_i = rnd_vec();
            noise_input_i = rnd_vec(); keyexpprod_i = 8'($urandom);
            step();
        end

        // final reset clears everything
        idle_ctrl();
        srst_i = 1;
        step();
        check("final_key_zero", key_o, '0);
        check("final_state_zero", state_o, '0);
        srst_i = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
